// File: rtl/k005297_cyclecntr.sv
// k005297_cyclecntr
// Timing/count front end for the function-trigger stage.
//   - ROT_LEN-step one-hot, active-low rotation strobe bus (o_ROT20_n).
//   - CNT_WIDTH-bit rotation-cycle counter, held in a recirculating shift
//     register and incremented bit-serially, LSB first, during steps
//     0..CNT_WIDTH-1. Bit k is presented on o_CYCLECNTR_LSB during step k so
//     downstream comparators can match constants one bit per step.
//   - Increment is sampled at step 0, clear at step ROT_LEN-1, and the
//     overflow of a max->0 wrap is flagged during step CNT_WIDTH.
//
// Optional build macro: K005297_CYCLECNTR_PRELOAD_EN
//   Adds i_PRELOAD / i_PRELOAD_VAL. A preload sampled at the last step loads
//   the counter on the wrap back to step 0 and takes priority over the clear.
//
// CNT_WIDTH must not exceed ROT_LEN/2 so the serial-add window and the
// last (clear/preload) step never overlap.

module k005297_cyclecntr #(
    parameter int CNT_WIDTH = 10,
    parameter int ROT_LEN   = 20
) (
    input  logic                 i_MCLK,
    input  logic                 i_RST,
    input  logic                 i_CLK2M_PCEN_n,
    input  logic                 i_HALT,
    input  logic                 i_CNT_INC,
    input  logic                 i_CNT_CLR,
`ifdef K005297_CYCLECNTR_PRELOAD_EN
    input  logic                 i_PRELOAD,
    input  logic [CNT_WIDTH-1:0] i_PRELOAD_VAL,
`endif
    output logic [ROT_LEN-1:0]   o_ROT20_n,
    output logic                 o_CYCLECNTR_LSB,
    output logic [CNT_WIDTH-1:0] o_CNT_VALUE,
    output logic                 o_CNT_OVF
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ROT_LEN-1:0]   rot_n;      // one-hot active-low step strobes
    logic [CNT_WIDTH-1:0] cnt_sr;     // counter, rotated right during adds
    logic                 carry;      // serial-adder carry between steps
    logic                 ovf;        // wrap flag, visible during step CNT_WIDTH

    // ------------------------------------------------------------------
    // Step decode (straight off the one-hot strobes, no separate counter)
    // ------------------------------------------------------------------
    logic cen;           // qualified clock enable
    logic step_first;    // step 0: increment request sampled here
    logic step_cnt_last; // step CNT_WIDTH-1: carry out of the MSB
    logic step_last;     // step ROT_LEN-1: clear/preload sampled here
    logic add_phase;     // steps 0..CNT_WIDTH-1

    assign cen           = ~i_CLK2M_PCEN_n;
    assign step_first    = ~rot_n[0];
    assign step_cnt_last = ~rot_n[CNT_WIDTH-1];
    assign step_last     = ~rot_n[ROT_LEN-1];
    assign add_phase     = ~&rot_n[CNT_WIDTH-1:0];

    // ------------------------------------------------------------------
    // Serial adder datapath
    // ------------------------------------------------------------------
    logic carry_in;
    logic sum_bit;
    logic carry_out;

    // Step 0 starts a fresh addition: the stored carry is replaced by the
    // (halt-gated) increment request; later steps propagate the carry.
    assign carry_in  = step_first ? (i_CNT_INC & ~i_HALT) : carry;
    assign sum_bit   = cnt_sr[0] ^ carry_in;
    assign carry_out = cnt_sr[0] & carry_in;

    // ------------------------------------------------------------------
    // Frame-boundary load (clear, or preload when built in)
    // ------------------------------------------------------------------
    logic                 load_en;
    logic [CNT_WIDTH-1:0] load_val;

    // Select what, if anything, replaces the counter on the wrap to step 0.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        load_en  = 1'b0;
        load_val = '0;
        if (step_last) begin
`ifdef K005297_CYCLECNTR_PRELOAD_EN
            if (i_PRELOAD) begin
                load_en  = 1'b1;
                load_val = i_PRELOAD_VAL;
            end else if (i_CNT_CLR) begin
                load_en  = 1'b1;
                load_val = '0;
            end
`else
            if (i_CNT_CLR) begin
                load_en  = 1'b1;
                load_val = '0;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state for the counter shift register
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] cnt_sr_next;

    // Rotate-and-add during the add window, load at the last step, else hold.
    always_comb begin
        cnt_sr_next = cnt_sr;
        if (add_phase) begin
            cnt_sr_next = {sum_bit, cnt_sr[CNT_WIDTH-1:1]};
        end else if (load_en) begin
            cnt_sr_next = load_val;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Rotator: walks the single low bit up one index per enable, wrapping.
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            rot_n <= {{(ROT_LEN-1){1'b1}}, 1'b0};
        end else if (cen) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values, independent of block order.
            rot_n <= {rot_n[ROT_LEN-2:0], rot_n[ROT_LEN-1]};
        end
    end

    // Counter shift register.
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            cnt_sr <= '0;
        end else if (cen) begin
            cnt_sr <= cnt_sr_next;
        end
    end

    // Carry between serial-add steps; only meaningful inside the add window.
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            carry <= 1'b0;
        end else if (cen && add_phase) begin
            carry <= carry_out;
        end
    end

    // Overflow: capture the MSB carry on the CNT_WIDTH-1 -> CNT_WIDTH step
    // and drop it again on the following enable, giving a one-step pulse.
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            ovf <= 1'b0;
        end else if (cen) begin
            ovf <= step_cnt_last & carry_out;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_ROT20_n       = rot_n;
    assign o_CYCLECNTR_LSB = add_phase & cnt_sr[0];
    assign o_CNT_VALUE     = cnt_sr;
    assign o_CNT_OVF       = ovf;

endmodule

// File: tb/tb_k005297_cyclecntr.sv
// Self-checking bench for k005297_cyclecntr.
// A frame-level model (step index plus integer counter values) is compared
// against the DUT on every falling edge; directed literal checks pin the
// model at the interesting points (703 pattern, wrap, halt, clear, reset).
// Build with +define+K005297_CYCLECNTR_PRELOAD_EN to also cover preload.

module tb_k005297_cyclecntr;

    localparam int W    = 10;
    localparam int R    = 20;
    localparam int CMAX = 1 << W;

    logic          i_MCLK = 1'b0;
    logic          i_RST = 1'b0;
    logic          i_CLK2M_PCEN_n = 1'b0;
    logic          i_HALT = 1'b0;
    logic          i_CNT_INC = 1'b0;
    logic          i_CNT_CLR = 1'b0;
`ifdef K005297_CYCLECNTR_PRELOAD_EN
    logic          i_PRELOAD = 1'b0;
    logic [W-1:0]  i_PRELOAD_VAL = '0;
`endif
    logic [R-1:0]  o_ROT20_n;
    logic          o_CYCLECNTR_LSB;
    logic [W-1:0]  o_CNT_VALUE;
    logic          o_CNT_OVF;

    k005297_cyclecntr #(.CNT_WIDTH(W), .ROT_LEN(R)) dut (
        .i_MCLK          (i_MCLK),
        .i_RST           (i_RST),
        .i_CLK2M_PCEN_n  (i_CLK2M_PCEN_n),
        .i_HALT          (i_HALT),
        .i_CNT_INC       (i_CNT_INC),
        .i_CNT_CLR       (i_CNT_CLR),
`ifdef K005297_CYCLECNTR_PRELOAD_EN
        .i_PRELOAD       (i_PRELOAD),
        .i_PRELOAD_VAL   (i_PRELOAD_VAL),
`endif
        .o_ROT20_n       (o_ROT20_n),
        .o_CYCLECNTR_LSB (o_CYCLECNTR_LSB),
        .o_CNT_VALUE     (o_CNT_VALUE),
        .o_CNT_OVF       (o_CNT_OVF)
    );

    always #5 i_MCLK = ~i_MCLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame-level model: which step we are in, the counter value at the
    // start of the frame (what is shown serially) and after the step-0
    // increment (what is shown in parallel), and whether the frame wrapped.
    // ------------------------------------------------------------------
    int m_step = 0;
    int m_cur  = 0;
    int m_nxt  = 0;
    bit m_ovf  = 1'b0;

    always @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            m_step = 0;
            m_cur  = 0;
            m_nxt  = 0;
            m_ovf  = 1'b0;
        end else if (!i_CLK2M_PCEN_n) begin
            if (m_step == 0) begin
                int add;
                add   = (i_CNT_INC && !i_HALT) ? 1 : 0;
                m_nxt = (m_cur + add) % CMAX;
                m_ovf = (add == 1) && (m_cur == CMAX - 1);
            end
            if (m_step == R - 1) begin
                m_cur = i_CNT_CLR ? 0 : m_nxt;
`ifdef K005297_CYCLECNTR_PRELOAD_EN
                if (i_PRELOAD) m_cur = int'(i_PRELOAD_VAL);
`endif
            end
            m_step = (m_step + 1) % R;
        end
    end

    // Continuous compare against the model on every falling edge.
    logic [R-1:0] exp_rot;
    always @(negedge i_MCLK) begin
        if (!i_RST) begin
            exp_rot = ~(R'(1) << m_step);
            check("rot", 32'(o_ROT20_n), 32'(exp_rot));
            check("lsb", 32'(o_CYCLECNTR_LSB), (m_step < W) ? ((m_cur >> m_step) & 1) : 0);
            if (m_step >= W) check("value", 32'(o_CNT_VALUE), 32'(m_nxt));
            check("ovf", 32'(o_CNT_OVF), (m_step == W && m_ovf) ? 1 : 0);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change just after the falling edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge i_MCLK);
        @(negedge i_MCLK);
    endtask

    task automatic frames(input int n);
        repeat (n * R) tick();
    endtask

    task automatic run_to_step(input int s);
        int guard;
        guard = 0;
        while (m_step != s && guard < 2 * R) begin
            tick();
            guard++;
        end
        check("run_to_step_timeout", 32'(m_step), 32'(s));
    endtask

    // Collect the serial bits of steps 0..W-1 (starting at step 0).
    task automatic grab_bits(output logic [W-1:0] bits);
        bits = '0;
        for (int k = 0; k < W; k++) begin
            bits[k] = o_CYCLECNTR_LSB;
            tick();
        end
    endtask

    logic [W-1:0] bits;

    initial begin
        #1 i_RST = 1'b1;
        @(negedge i_MCLK);
        @(negedge i_MCLK);
        check("reset_rot", 32'(o_ROT20_n), 32'h000F_FFFE);
        check("reset_value", 32'(o_CNT_VALUE), 0);
        check("reset_ovf", 32'(o_CNT_OVF), 0);
        check("reset_lsb", 32'(o_CYCLECNTR_LSB), 0);
        i_RST = 1'b0;

        // Rotator sweep with no increments: 40 enables.
        tick();
        check("rot_step1", 32'(o_ROT20_n), 32'h000F_FFFD);
        for (int i = 2; i <= 40; i++) begin
            tick();
            if (i == 19) check("rot_step19", 32'(o_ROT20_n), 32'h0007_FFFF);
            check("idle_lsb", 32'(o_CYCLECNTR_LSB), 0);
        end
        check("rot_wrap40", 32'(o_ROT20_n), 32'h000F_FFFE);

        // Clock enable held off: nothing moves.
        i_CLK2M_PCEN_n = 1'b1;
        repeat (3) tick();
        check("pcen_hold_rot", 32'(o_ROT20_n), 32'h000F_FFFE);
        i_CLK2M_PCEN_n = 1'b0;

        // Count 702 frames, then frame 703 shows 702 serially and 703 in parallel.
        i_CNT_INC = 1'b1;
        frames(702);
        grab_bits(bits);
        check("bits_702", 32'(bits), 32'(10'b1010111110));
        check("value_703", 32'(o_CNT_VALUE), 703);

        // Advance to a frame starting at 1023, then wrap (clear in same frame).
        run_to_step(0);
        frames(320);
        check("pre_wrap_value", 32'(o_CNT_VALUE), 1023);
        repeat (9) tick();
        check("ovf_step9", 32'(o_CNT_OVF), 0);
        tick();
        check("ovf_step10", 32'(o_CNT_OVF), 1);
        check("wrap_value", 32'(o_CNT_VALUE), 0);
        tick();
        check("ovf_step11", 32'(o_CNT_OVF), 0);
        run_to_step(19);
        i_CNT_CLR = 1'b1;
        tick();
        i_CNT_CLR = 1'b0;
        check("clr_ovf_value", 32'(o_CNT_VALUE), 0);

        // Halt for 5 frames from 97.
        frames(97);
        i_HALT = 1'b1;
        frames(5);
        repeat (10) tick();
        check("halt_value", 32'(o_CNT_VALUE), 97);
        check("halt_rot_step10", 32'(o_ROT20_n), 32'h000F_FBFF);
        i_HALT = 1'b0;

        // Reach 623 then clear at step 19 with increment still requested.
        run_to_step(0);
        frames(525);
        run_to_step(19);
        check("value_623", 32'(o_CNT_VALUE), 623);
        i_CNT_CLR = 1'b1;
        tick();
        i_CNT_CLR = 1'b0;
        grab_bits(bits);
        check("bits_after_clr", 32'(bits), 0);
        check("value_after_clr", 32'(o_CNT_VALUE), 1);

        // Halt rising mid-frame does not abort the increment in progress.
        run_to_step(0);
        tick();
        i_HALT = 1'b1;
        run_to_step(10);
        check("halt_midframe_value", 32'(o_CNT_VALUE), 2);
        i_HALT = 1'b0;

        // Asynchronous reset at step 7 of a counting frame.
        run_to_step(7);
        #2 i_RST = 1'b1;
        #1;
        check("async_rst_rot", 32'(o_ROT20_n), 32'h000F_FFFE);
        check("async_rst_value", 32'(o_CNT_VALUE), 0);
        check("async_rst_ovf", 32'(o_CNT_OVF), 0);
        @(negedge i_MCLK);
        i_RST = 1'b0;
        frames(2);

`ifdef K005297_CYCLECNTR_PRELOAD_EN
        // Preload 702 (with a competing clear) at step 19.
        run_to_step(19);
        i_PRELOAD     = 1'b1;
        i_PRELOAD_VAL = 10'd702;
        i_CNT_CLR     = 1'b1;
        tick();
        i_PRELOAD = 1'b0;
        i_CNT_CLR = 1'b0;
        grab_bits(bits);
        check("preload_bits", 32'(bits), 32'(10'b1010111110));
        check("preload_value", 32'(o_CNT_VALUE), 703);
`endif

        frames(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
